// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution for Thumb control flow, with a direct-mapped
// BTB for fetch-stage prediction and registered redirect/flush on a mispredict.
module branch_resolve_unit #(
  parameter int WORD        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WORD-1:0]  fetch_pc_i,
  output logic             pred_taken_o,
  output logic [WORD-1:0]  pred_target_o,
  input  logic             is_valid_i,
  input  logic [15:0]      instruction_i,
  input  logic [3:0]       status_reg_i,
  input  logic [WORD-1:0]  program_counter_i,
  input  logic [WORD-1:0]  reg_data_1_i,
  input  logic [WORD-1:0]  immediate_i,
  input  logic             pred_taken_i,
  input  logic [WORD-1:0]  pred_target_i,
  output logic             take_branch_o,
  output logic             flush_pipeline_o,
  output logic [WORD-1:0]  program_counter_o,
  output logic             bl_error_o,
  output logic [CNT_W-1:0] mispredict_count_o
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD - IDX - 1;

  typedef enum logic [0:0] {IDLE = 1'b0, PREFIX = 1'b1} bl_state_t;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = ~z;
      4'h2:    cond_pass = c;
      4'h3:    cond_pass = ~c;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = ~n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = ~v;
      4'h8:    cond_pass = c & ~z;
      4'h9:    cond_pass = ~c | z;
      4'ha:    cond_pass = (n == v);
      4'hb:    cond_pass = (n != v);
      4'hc:    cond_pass = ~z & (n == v);
      4'hd:    cond_pass = z | (n != v);
      4'he:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic             valid_r  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_r    [BTB_ENTRIES];
  logic [WORD-1:0]  target_r [BTB_ENTRIES];
  logic [1:0]       ctr_r    [BTB_ENTRIES];

  bl_state_t        state_r, state_next_s;
  logic             take_r, bl_err_r, bl_err_s;
  logic [WORD-1:0]  pc_r;
  logic [CNT_W-1:0] cnt_r;

  logic             ev_s, is_branch_s, taken_s, rd_pc_s, is_prefix_s, is_suffix_s;
  logic [WORD-1:0]  target_s, redirect_s;
  logic             mispredict_s, upd_en_s, upd_hit_s;
  logic [IDX-1:0]   fetch_idx_s, upd_idx_s;
  logic             unused_ok_s;

  assign ev_s        = is_valid_i & ~take_r;
  assign rd_pc_s     = ({instruction_i[7], instruction_i[2:0]} == 4'b1111);
  assign is_prefix_s = (instruction_i[15:11] == 5'b11110);
  assign is_suffix_s = (instruction_i[15:11] == 5'b11101) || (instruction_i[15:11] == 5'b11111);
  assign fetch_idx_s = fetch_pc_i[IDX:1];
  assign upd_idx_s   = program_counter_i[IDX:1];
  assign upd_hit_s   = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == program_counter_i[WORD-1:IDX+1]);
  assign unused_ok_s = ^{instruction_i[6:3], fetch_pc_i[0]};

  // Fetch-stage BTB lookup; predicts taken only on a hit with a strong/weak-taken counter.
  always_comb begin
    pred_taken_o  = 1'b0;
    pred_target_o = {WORD{1'b0}};
    if (valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_pc_i[WORD-1:IDX+1])
        && ctr_r[fetch_idx_s][1]) begin
      pred_taken_o  = 1'b1;
      pred_target_o = target_r[fetch_idx_s];
    end else begin
      pred_taken_o  = 1'b0;
    end
  end

  // Decode the execute-stage halfword into branch class, actual outcome and target.
  always_comb begin
    is_branch_s = 1'b0;
    taken_s     = 1'b0;
    target_s    = program_counter_i + immediate_i;
    if ((instruction_i[15:12] == 4'b1101) && (instruction_i[11:8] != 4'b1111)) begin
      is_branch_s = 1'b1;
      taken_s     = cond_pass(instruction_i[11:8], status_reg_i);
    end else if (instruction_i[15:11] == 5'b11100) begin
      is_branch_s = 1'b1;
      taken_s     = 1'b1;
    end else if (instruction_i[15:10] == 6'b010001) begin
      case (instruction_i[9:8])
        2'b00: begin
          is_branch_s = rd_pc_s;
          taken_s     = rd_pc_s;
          target_s    = program_counter_i + reg_data_1_i;
        end
        2'b10: begin
          is_branch_s = rd_pc_s;
          taken_s     = rd_pc_s;
          target_s    = reg_data_1_i;
        end
        2'b11: begin
          is_branch_s = 1'b1;
          taken_s     = 1'b1;
          target_s    = reg_data_1_i;
        end
        default: begin
          is_branch_s = 1'b0;
        end
      endcase
    end else if (is_suffix_s && (state_r == PREFIX)) begin
      is_branch_s = 1'b1;
      taken_s     = 1'b1;
    end else begin
      is_branch_s = 1'b0;
    end
  end

  assign mispredict_s = ev_s && ((taken_s != pred_taken_i) || (taken_s && (target_s != pred_target_i)));
  assign redirect_s   = taken_s ? target_s : program_counter_i + {{(WORD-2){1'b0}}, 2'b10};
  assign upd_en_s     = ev_s & is_branch_s;

  // BL pairing: squashed/bubble cycles hold the prefix state.
  always_comb begin
    state_next_s = state_r;
    bl_err_s     = 1'b0;
    if (ev_s) begin
      case (state_r)
        IDLE:    state_next_s = is_prefix_s ? PREFIX : IDLE;
        PREFIX: begin
          state_next_s = IDLE;
          bl_err_s     = ~is_suffix_s;
        end
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // BL state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_next_s;
  end

  // Registered redirect, flush, BL error pulse and saturating mispredict count.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      take_r   <= 1'b0;
      bl_err_r <= 1'b0;
      pc_r     <= {WORD{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      take_r   <= mispredict_s;
      bl_err_r <= bl_err_s;
      if (mispredict_s) begin
        pc_r <= redirect_s;
        if (cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // BTB valid bits; only these need reset since every read is qualified by valid.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) valid_r[i] <= 1'b0;
    end else if (upd_en_s && taken_s) begin
      valid_r[upd_idx_s] <= 1'b1;
    end
  end

  // BTB payload: allocate on taken miss, train counter and target on hit.
  always_ff @(posedge clk_i) begin
    if (upd_en_s) begin
      if (taken_s) begin
        tag_r[upd_idx_s]    <= program_counter_i[WORD-1:IDX+1];
        target_r[upd_idx_s] <= target_s;
        ctr_r[upd_idx_s]    <= upd_hit_s ? ctr_inc(ctr_r[upd_idx_s]) : 2'b10;
      end else if (upd_hit_s) begin
        ctr_r[upd_idx_s]    <= ctr_dec(ctr_r[upd_idx_s]);
      end
    end
  end

  assign take_branch_o      = take_r;
  assign flush_pipeline_o   = take_r;
  assign program_counter_o  = pc_r;
  assign bl_error_o         = bl_err_r;
  assign mispredict_count_o = cnt_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: each driven instruction pushes its
// expected registered outcome, popped and compared one cycle later.
module tb_branch_resolve_unit;
  logic        clk, reset_n;
  logic [31:0] fetch_pc, pc, rd1, imm, ptgt;
  logic        is_valid, pt;
  logic [15:0] instruction;
  logic [3:0]  status;

  logic        pred_taken, take, flush, blerr;
  logic [31:0] pred_target, pc_o;
  logic [15:0] cnt;
  logic        s_pred_taken, s_take, s_flush, s_blerr;
  logic [31:0] s_pred_target, s_pc_o;
  logic [1:0]  s_cnt;

  typedef struct {
    logic        take;
    logic [31:0] pc;
    logic        blerr;
    logic [15:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;

  branch_resolve_unit dut (
    .clk_i(clk), .reset_n_i(reset_n), .fetch_pc_i(fetch_pc),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .is_valid_i(is_valid), .instruction_i(instruction), .status_reg_i(status),
    .program_counter_i(pc), .reg_data_1_i(rd1), .immediate_i(imm),
    .pred_taken_i(pt), .pred_target_i(ptgt),
    .take_branch_o(take), .flush_pipeline_o(flush), .program_counter_o(pc_o),
    .bl_error_o(blerr), .mispredict_count_o(cnt)
  );

  branch_resolve_unit #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .reset_n_i(reset_n), .fetch_pc_i(fetch_pc),
    .pred_taken_o(s_pred_taken), .pred_target_o(s_pred_target),
    .is_valid_i(is_valid), .instruction_i(instruction), .status_reg_i(status),
    .program_counter_i(pc), .reg_data_1_i(rd1), .immediate_i(imm),
    .pred_taken_i(pt), .pred_target_i(ptgt),
    .take_branch_o(s_take), .flush_pipeline_o(s_flush), .program_counter_o(s_pc_o),
    .bl_error_o(s_blerr), .mispredict_count_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [15:0] ins, input logic [3:0] fl,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                      input logic ptk, input logic [31:0] ptg,
                      input logic et, input logic [31:0] ep, input logic eb);
    exp_t e;
    is_valid = v; instruction = ins; status = fl; pc = p; imm = im; rd1 = r1;
    pt = ptk; ptgt = ptg;
    if (et) exp_cnt++;
    e.take = et; e.pc = ep; e.blerr = eb; e.cnt = 16'(exp_cnt);
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic bubble();
    step(1'b0, 16'h0000, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; fetch_pc = 32'h100; is_valid = 1'b0; instruction = 16'h0;
    status = 4'h0; pc = 32'h0; rd1 = 32'h0; imm = 32'h0; pt = 1'b0; ptgt = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({pred_taken, take, flush, blerr, s_pred_taken} !== 5'b0 || pred_target !== 32'h0
        || pc_o !== 32'h0 || cnt !== 16'h0 || s_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset: pred=%b tgt=%h take=%b flush=%b pc=%h blerr=%b cnt=%0d want all 0",
               pred_taken, pred_target, take, flush, pc_o, blerr, cnt);
    end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_beq_mispredict();
    exp_t e;
    logic [1:0] es;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: step(1'b1, 16'hD000, 4'b0100, 32'h100, 32'h20, 32'h0, 1'b0, 32'h0, 1'b1, 32'h120, 1'b0);
        default: bubble();
      endcase
      e = sbq.pop_front();
      es = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      checks++;
      if (take !== e.take || flush !== e.take || (e.take && pc_o !== e.pc) || blerr !== e.blerr
          || cnt !== e.cnt || s_cnt !== es) begin
        failures++;
        $display("FAIL beq_mis[%0d]: take=%b flush=%b pc=%h blerr=%b cnt=%0d/%0d want take=%b pc=%h blerr=%b cnt=%0d/%0d",
                 s, take, flush, pc_o, blerr, cnt, s_cnt, e.take, e.pc, e.blerr, e.cnt, es);
      end
      if (s == 0) begin
        fetch_pc = 32'h100; #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
          failures++;
          $display("FAIL btb_alloc: pred=%b tgt=%h want 1 00000120", pred_taken, pred_target);
        end
      end
    end
  endtask

  task automatic test_beq_predicted();
    exp_t e;
    logic [1:0] es;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: step(1'b1, 16'hD000, 4'b0100, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 1'b0, 32'h0, 1'b0);
        1: step(1'b1, 16'hD000, 4'b0000, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 1'b1, 32'h102, 1'b0);
        3: step(1'b1, 16'hD000, 4'b0000, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 1'b1, 32'h102, 1'b0);
        default: bubble();
      endcase
      e = sbq.pop_front();
      es = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      checks++;
      if (take !== e.take || flush !== e.take || (e.take && pc_o !== e.pc) || blerr !== e.blerr
          || cnt !== e.cnt || s_cnt !== es) begin
        failures++;
        $display("FAIL beq_pred[%0d]: take=%b flush=%b pc=%h blerr=%b cnt=%0d/%0d want take=%b pc=%h blerr=%b cnt=%0d/%0d",
                 s, take, flush, pc_o, blerr, cnt, s_cnt, e.take, e.pc, e.blerr, e.cnt, es);
      end
      if (s == 2 || s == 4) begin
        fetch_pc = 32'h100; #1;
        checks++;
        if (pred_taken !== (s == 2) || pred_target !== ((s == 2) ? 32'h120 : 32'h0)) begin
          failures++;
          $display("FAIL btb_ctr[%0d]: pred=%b tgt=%h want %b", s, pred_taken, pred_target, (s == 2));
        end
      end
    end
  endtask

  task automatic test_bl();
    exp_t e;
    logic [1:0] es;
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: step(1'b1, 16'hF000, 4'h0, 32'h1FE, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        2: step(1'b1, 16'hF800, 4'h0, 32'h200, 32'h1000, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1200, 1'b0);
        4: step(1'b1, 16'hF000, 4'h0, 32'h210, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        5: step(1'b1, 16'h4400, 4'h0, 32'h212, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        default: bubble();
      endcase
      e = sbq.pop_front();
      es = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      checks++;
      if (take !== e.take || flush !== e.take || (e.take && pc_o !== e.pc) || blerr !== e.blerr
          || cnt !== e.cnt || s_cnt !== es) begin
        failures++;
        $display("FAIL bl[%0d]: take=%b flush=%b pc=%h blerr=%b cnt=%0d/%0d want take=%b pc=%h blerr=%b cnt=%0d/%0d",
                 s, take, flush, pc_o, blerr, cnt, s_cnt, e.take, e.pc, e.blerr, e.cnt, es);
      end
      if (s == 2) begin
        fetch_pc = 32'h200; #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h1200) begin
          failures++;
          $display("FAIL bl_btb: pred=%b tgt=%h want 1 00001200", pred_taken, pred_target);
        end
      end
    end
  endtask

  task automatic test_bx_squash();
    exp_t e;
    logic [1:0] es;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: step(1'b1, 16'h4718, 4'h0, 32'h300, 32'h0, 32'h4000, 1'b1, 32'h3000, 1'b1, 32'h4000, 1'b0);
        1: step(1'b1, 16'hD000, 4'b0100, 32'h500, 32'h40, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        default: bubble();
      endcase
      e = sbq.pop_front();
      es = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      checks++;
      if (take !== e.take || flush !== e.take || (e.take && pc_o !== e.pc) || blerr !== e.blerr
          || cnt !== e.cnt || s_cnt !== es) begin
        failures++;
        $display("FAIL bx[%0d]: take=%b flush=%b pc=%h blerr=%b cnt=%0d/%0d want take=%b pc=%h blerr=%b cnt=%0d/%0d",
                 s, take, flush, pc_o, blerr, cnt, s_cnt, e.take, e.pc, e.blerr, e.cnt, es);
      end
      if (s == 0) begin
        fetch_pc = 32'h300; #1;
        checks++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h4000) begin
          failures++;
          $display("FAIL bx_btb: pred=%b tgt=%h want 1 00004000", pred_taken, pred_target);
        end
      end
      if (s == 2) begin
        fetch_pc = 32'h500; #1;
        checks++;
        if (pred_taken !== 1'b0) begin
          failures++;
          $display("FAIL squash_btb: pred=%b want 0", pred_taken);
        end
      end
    end
  endtask

  task automatic test_reset_mid_bl();
    exp_t e;
    step(1'b1, 16'hF000, 4'h0, 32'h600, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (take !== e.take || blerr !== e.blerr || cnt !== e.cnt) begin
      failures++;
      $display("FAIL mid_bl_prefix: take=%b blerr=%b cnt=%0d want %b %b %0d",
               take, blerr, cnt, e.take, e.blerr, e.cnt);
    end
    fetch_pc = 32'h300;
    reset_n = 1'b0; #1;
    exp_cnt = 0;
    checks++;
    if (take !== 1'b0 || cnt !== 16'h0 || s_cnt !== 2'd0 || pred_taken !== 1'b0 || pc_o !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: take=%b cnt=%0d pred=%b pc=%h want 0", take, cnt, pred_taken, pc_o);
    end
    reset_n = 1'b1; #1;
    step(1'b1, 16'hF800, 4'h0, 32'h610, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    e = sbq.pop_front();
    checks++;
    if (take !== e.take || flush !== e.take || blerr !== e.blerr || cnt !== e.cnt) begin
      failures++;
      $display("FAIL suffix_after_reset: take=%b blerr=%b cnt=%0d want %b %b %0d",
               take, blerr, cnt, e.take, e.blerr, e.cnt);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [1:0]  es;
    logic [15:0] ins;
    logic [3:0]  fl;
    logic [31:0] p, tgt;
    for (int s = 0; s < 12; s++) begin
      if (s % 2 == 0) begin
        p = 32'h700 + 32'(s * 16);
        fl = 4'h0;
        case ((s / 2) % 5)
          0: begin ins = 16'hE000; tgt = p + 32'h40; end
          1: begin ins = 16'h46F7; tgt = 32'hFFFF_FFF0; end
          2: begin ins = 16'h44FF; tgt = p - 32'h10; end
          3: begin ins = 16'hDC00; tgt = p + 32'h40; end
          default: begin ins = 16'hDB00; fl = 4'b1000; tgt = p + 32'h40; end
        endcase
        step(1'b1, ins, fl, p, 32'h40, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b1, tgt, 1'b0);
      end else begin
        bubble();
      end
      e = sbq.pop_front();
      es = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      checks++;
      if (take !== e.take || flush !== e.take || (e.take && pc_o !== e.pc) || blerr !== e.blerr
          || cnt !== e.cnt || s_cnt !== es) begin
        failures++;
        $display("FAIL sat[%0d]: take=%b flush=%b pc=%h blerr=%b cnt=%0d/%0d want take=%b pc=%h blerr=%b cnt=%0d/%0d",
                 s, take, flush, pc_o, blerr, cnt, s_cnt, e.take, e.pc, e.blerr, e.cnt, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_beq_predicted();
    test_bl();
    test_bx_squash();
    test_reset_mid_bl();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised successor to the execute-stage branch controller. It resolves every control-flow instruction: Thumb conditional and unconditional branches, PC-writing ADD/MOV, BX/BLX and the two-halfword BL pair. It adds a direct-mapped branch target buffer (BTB) with 2-bit counters for the fetch stage. It redirects and flushes the pipeline only on a misprediction, through registered outputs.

## Interface
- WORD, 32: datapath and PC width.
- BTB_ENTRIES, 16: BTB depth; power of two, at least 2; IDX = log2(BTB_ENTRIES).
- CNT_W, 16: width of the saturating mispredict counter.
- clk_i  in  1  single clock, rising edge.
- reset_n_i  in  1  reset, asynchronous and active-low.
- fetch_pc_i  in  WORD  fetch-stage PC for BTB lookup.
- pred_taken_o  out  1  BTB prediction for fetch_pc_i (combinational).
- pred_target_o  out  WORD  predicted target; 0 when pred_taken_o=0.
- is_valid_i  in  1  execute-stage instruction valid.
- instruction_i  in  16  execute-stage Thumb halfword.
- status_reg_i  in  4  {N,Z,C,V} flags.
- program_counter_i  in  WORD  PC value used for target arithmetic.
- reg_data_1_i  in  WORD  Rm operand for register-indirect branches.
- immediate_i  in  WORD  sign-extended byte offset.
- pred_taken_i  in  1  prediction carried down the pipe with this instruction.
- pred_target_i  in  WORD  predicted target carried down the pipe.
- take_branch_o  out  1  registered redirect strobe.
- flush_pipeline_o  out  1  registered flush strobe; equals take_branch_o.
- program_counter_o  out  WORD  registered redirect PC.
- bl_error_o  out  1  registered 1-cycle pulse: BL prefix not followed by a suffix.
- mispredict_count_o  out  CNT_W  saturating count of redirects.

## Operation
- Effective valid: ev = is_valid_i & ~flush_pipeline_o. The instruction in execute during a flush cycle is wrong-path. It is squashed: no BTB update, no FSM change, no redirect.

Decode and actual outcome (taken, target):
- [15:12]=1101, cond in 0000..1110: standard ARM conditions EQ..AL on the flags. Target = pc+imm. cond 1111 is not a branch.
- [15:11]=11100: always taken; target = pc+imm.
- [15:10]=010001, [9:8]=00 (ADD) with Rd={[7],[2:0]}=15: taken; target = pc+reg_data_1_i.
- [15:10]=010001, [9:8]=10 (MOV) with Rd=15: taken; target = reg_data_1_i.
- [15:10]=010001, [9:8]=11 (BX/BLX): taken; target = reg_data_1_i.
- BL prefix [15:11]=11110, suffix [15:11] in {11101,11111}: handled by the FSM below.
- All other instructions: not a branch. They are treated as not taken with pred ignored; mispredict if pred_taken_i=1.
- All adds are modulo 2^WORD.

BL FSM (states IDLE, PREFIX):
- IDLE + ev prefix: go to PREFIX. The prefix itself is not taken.
- PREFIX + ev suffix: taken, target = pc+imm; go to IDLE.
- PREFIX + ev non-suffix: go to IDLE and pulse bl_error_o next cycle. That instruction is still resolved normally.
- PREFIX + !ev: hold PREFIX.
- A suffix seen in IDLE is not a branch.

Mispredict and redirect:
- Branch-class mispredict: ev & (taken != pred_taken_i | (taken & target != pred_target_i)).
- Redirect PC: target if taken, else program_counter_i+2.
- On mispredict, the following are registered: take_branch_o=flush_pipeline_o=1, program_counter_o = redirect PC, mispredict_count_o += 1 (saturating at all-ones).

BTB:
- index = pc[IDX:1]; tag = pc[WORD-1:IDX+1]; each entry holds {valid, tag, target, ctr[1:0]}.
- Lookup: hit = valid & tag match. pred_taken_o = hit & ctr[1]. pred_target_o = hit&ctr[1] ? target : 0.
- Update on ev branch-class instructions (a BL updates on its suffix only), indexed by program_counter_i:
  - taken & hit: ctr saturating increment; target rewritten.
  - taken & miss: allocate, overwriting any entry; ctr=10.
  - not-taken & hit: ctr saturating decrement.
  - not-taken & miss: no change.

## Timing
- Reset (asynchronous, while reset_n_i=0):
  - take_branch_o=0, flush_pipeline_o=0, program_counter_o=0, bl_error_o=0, mispredict_count_o=0.
  - FSM=IDLE and all BTB valid bits = 0, so pred_taken_o=0 and pred_target_o=0.
- Resolve-to-redirect latency is 1 cycle. Outputs hold for exactly one cycle unless the next ev instruction also mispredicts; that cannot occur because of squashing.
- A BTB write at edge N is visible to lookup from cycle N+1. A same-cycle lookup of the entry being written returns the old contents.
- Reset asserted mid-BL (in PREFIX) returns the FSM to IDLE; the suffix after reset is not a branch.
- A correctly predicted branch produces no flush and no count change.

## Test plan
- Reset with fetch_pc_i=0x100 -> pred_taken_o=0, all outputs 0.
- BEQ (0xD0xx) with Z=1, pc=0x100, imm=0x20, pred_taken_i=0 -> next cycle take_branch_o=flush_pipeline_o=1, program_counter_o=0x120, mispredict_count_o=1. A lookup of 0x100 the following cycle gives pred_taken_o=1, pred_target_o=0x120.
- Same BEQ, Z=1, pred_taken_i=1, pred_target_i=0x120 -> no flush. Then Z=0 twice -> first resolve flushes to 0x102 and ctr drops to 10; second resolve (pred_taken_i=1) flushes again, ctr drops to 01, pred_taken_o=0.
- BL prefix, one bubble, suffix with pc=0x200, imm=0x1000 -> redirect to 0x1200. Prefix followed by ADD r0 -> bl_error_o pulse, no redirect.
- BX r3 with r3=0x4000, pred_taken_i=1, pred_target_i=0x3000 -> redirect to 0x4000. The instruction presented in the flush cycle with is_valid_i=1 causes no action.
- Force mispredict_count_o to all-ones with CNT_W=2 -> the fourth mispredict leaves the count at 3.
